clk_div_n: RTL

Runtime-programmable integer clock divider producing `clk_o` at `clk`/N with 50 % duty cycle for both odd and even N. N ranges from 2 to 2^WIDTH-1. Divisor changes and enable/disable take effect only at period boundaries, so `clk_o` never emits a runt pulse. The block is the generalised successor of the fixed divide-by-3 generator and feeds downstream clock-gating and peripheral-clock logic. It also provides a `clk`-domain tick for logic that stays on the source clock.

---
 rtl/clk_div_n.sv | 113 +++++++++++
 1 files changed

// File: rtl/clk_div_n.sv
// Runtime-programmable integer clock divider, 50% duty for odd and even N.
// Divisor and enable changes are applied only at period boundaries.
module clk_div_n #(
  parameter int WIDTH     = 8,
  parameter int DIV_RESET = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             div_load_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             run_o,
  output logic [WIDTH-1:0] div_o,
  output logic             pend_o,
  output logic             err_o
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             p_q, p_d;
  logic             n_q;
  logic             tick_q, tick_d;
  logic             err_q;

  logic ld_ok, ld_bad, terminal;

  assign ld_ok    = div_load_i && (div_i > WIDTH'(1));
  assign ld_bad   = div_load_i && (div_i < WIDTH'(2));
  assign terminal = (state_q == ST_RUN) && (cnt_q == div_act_q - WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    tick_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ld_ok) div_act_d = div_i;
        if (en_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          tick_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (terminal) begin
          // A load in the terminal cycle wins over anything still pending.
          cnt_d  = '0;
          pend_d = 1'b0;
          if (ld_ok)       div_act_d = div_i;
          else if (pend_q) div_act_d = div_pend_q;
          if (en_i) tick_d  = 1'b1;
          else      state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
          if (ld_ok) begin
            div_pend_d = div_i;
            pend_d     = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // High half of the period uses the divisor that governs the coming cycle.
    p_d = (state_d == ST_RUN) && (cnt_d < (div_act_d >> 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_act_q  <= WIDTH'(DIV_RESET);
      div_pend_q <= WIDTH'(DIV_RESET);
      pend_q     <= 1'b0;
      p_q        <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      p_q        <= p_d;
      tick_q     <= tick_d;
      err_q      <= ld_bad;
    end
  end

  // Half-cycle extension for odd divisors; n is always 0 at a boundary,
  // so the parity mask can switch there without a glitch.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) n_q <= 1'b0;
    else        n_q <= p_q;
  end

  assign clk_o  = p_q | (n_q & div_act_q[0]);
  assign tick_o = tick_q;
  assign run_o  = (state_q == ST_RUN);
  assign div_o  = div_act_q;
  assign pend_o = pend_q;
  assign err_o  = err_q;

endmodule
